// File: rtl/x25519_pkg.sv
// x25519_pkg: shared definitions for the X25519 Montgomery-ladder sequencer.
//   ladder_state_e - sequencer FSM states
//   NUM_ITER       - ladder iterations per scalar multiplication
//   POS_START      - first scalar bit position visited by the ladder
//   clamp_scalar   - X25519 scalar clamping
package x25519_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } ladder_state_e;

  localparam int         NUM_ITER  = 255;
  localparam logic [7:0] POS_START = 8'(NUM_ITER - 1);

  // Low three bits cleared (cofactor), top bit cleared, bit 254 forced set.
  function automatic logic [255:0] clamp_scalar(input logic [255:0] e);
    logic [255:0] c;
    c        = e;
    c[2:0]   = 3'b000;
    c[255]   = 1'b0;
    c[254]   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/x25519_ladder_sequencer.sv
// x25519_ladder_sequencer: walks the clamped scalar from bit 254 down to bit 0,
// handing one Montgomery-ladder step at a time to an external iteration unit
// and collecting its result.
//   clk, rst            - clock, synchronous active-high reset
//   start, scalar, u_in - request, scalar e and base-point u (sampled on accept)
//   busy, done, xz_out  - run in progress, completion pulse, final {z, x}
//   iter_en             - one-cycle request to the iteration unit
//   iter_xzm, iter_xzm1 - current ladder operands {z, x}
//   iter_b              - current clamped scalar bit
//   iter_work_low       - {8'h0, u}
//   iter_valid, iter_xzm_res, iter_xzm1_res - iteration result
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// ISSUE  | iter_en high for one cycle with stable operands
// WAIT   | waiting (unbounded) for iter_valid
// FINISH | done pulse; xz_out already holds the final xzm
module x25519_ladder_sequencer
  import x25519_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] scalar,
  input  logic [255:0] u_in,
  output logic         busy,
  output logic         done,
  output logic [511:0] xz_out,
  output logic         iter_en,
  output logic [511:0] iter_xzm,
  output logic [511:0] iter_xzm1,
  output logic         iter_b,
  output logic [263:0] iter_work_low,
  input  logic         iter_valid,
  input  logic [511:0] iter_xzm_res,
  input  logic [511:0] iter_xzm1_res
);

  ladder_state_e state, state_nxt;
  logic [255:0]  scalar_q;
  logic [7:0]    pos;
  logic          accept;
  logic          take_res;
  logic          last_iter;

  assign last_iter = (pos == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    iter_en   = 1'b0;
    accept    = 1'b0;
    take_res  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy      = 1'b1;
        iter_en   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (iter_valid) begin
          take_res  = 1'b1;
          state_nxt = last_iter ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands only change on accept or on an accepted result, so they stay
  // stable from iter_en until the matching iter_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      scalar_q      <= '0;
      pos           <= 8'd0;
      iter_xzm      <= '0;
      iter_xzm1     <= '0;
      iter_work_low <= '0;
      xz_out        <= '0;
    end else begin
      if (accept) begin
        scalar_q      <= clamp_scalar(scalar);
        pos           <= POS_START;
        iter_xzm      <= {256'h0, 256'h1};
        iter_xzm1     <= {256'h1, u_in};
        iter_work_low <= {8'h0, u_in};
      end
      if (take_res) begin
        iter_xzm  <= iter_xzm_res;
        iter_xzm1 <= iter_xzm1_res;
        if (!last_iter) pos <= pos - 8'd1;
      end
      // Final xzm is captured on the way into FINISH so xz_out is already
      // valid while done is high, and held until the next completion.
      if (take_res && last_iter) xz_out <= iter_xzm_res;
    end
  end

  assign iter_b = scalar_q[pos];

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// tb_x25519_ladder_sequencer: scoreboard bench for x25519_ladder_sequencer.
// A responder process models the ladder-iteration unit (loopback, random
// results, or a real field-arithmetic ladder step) and pushes the expected
// next DUT event; a monitor pops and compares on every iter_en / done.
`timescale 1ns/1ps
module tb_x25519_ladder_sequencer;
  import x25519_pkg::*;

  localparam logic [255:0] P = {1'b0, {250{1'b1}}, 5'b01101};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] scalar, u_in;
  logic         busy, done, iter_en, iter_b, iter_valid;
  logic [511:0] xz_out, iter_xzm, iter_xzm1, iter_xzm_res, iter_xzm1_res;
  logic [263:0] iter_work_low;

  x25519_ladder_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar), .u_in(u_in),
    .busy(busy), .done(done), .xz_out(xz_out), .iter_en(iter_en),
    .iter_xzm(iter_xzm), .iter_xzm1(iter_xzm1), .iter_b(iter_b),
    .iter_work_low(iter_work_low), .iter_valid(iter_valid),
    .iter_xzm_res(iter_xzm_res), .iter_xzm1_res(iter_xzm1_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           first;
    bit           is_done;
    int           cyc;
    logic         b;
    logic [511:0] m;
    logic [511:0] m1;
    logic [263:0] w;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // stimulus-owned
  int           epoch = 0;
  int           mode = 0;
  bit           rand_delay = 0;
  bit           inject_issue = 0;
  int           stray_req = 0;
  int           run_base = 0;
  logic [255:0] exp_clamped = '0;
  logic [263:0] exp_work = '0;
  // responder-owned
  int           stray_done = 0;
  bit           resp_busy = 0;
  // monitor-owned
  int           en_total = 0;
  int           en_cnt = 0;
  int           done_cnt = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] bswap(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[8*(31-i) +: 8];
    return r;
  endfunction

  // Byte-level clamp as written in RFC 7748 (k[0] &= 248; k[31] &= 127; k[31] |= 64).
  function automatic logic [255:0] clamp_ref(input logic [255:0] e);
    logic [7:0]   by [32];
    logic [255:0] r;
    for (int i = 0; i < 32; i++) by[i] = e[8*i +: 8];
    by[0]  = by[0] & 8'd248;
    by[31] = (by[31] & 8'd127) | 8'd64;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = by[i];
    return r;
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'h0, a} * {256'h0, b};
    t = t % {256'h0, P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    return fadd(a, P - b);
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] z);
    logic [255:0] r, b, e;
    r = 256'd1;
    b = z;
    e = P - 256'd2;
    for (int i = 0; i < 255; i++) begin
      if (e[i]) r = fmul(r, b);
      b = fmul(b, b);
    end
    return r;
  endfunction

  task automatic ladder_step(input logic kb, input logic [255:0] u,
                             input logic [511:0] m, input logic [511:0] m1,
                             output logic [511:0] rm, output logic [511:0] rm1);
    logic [255:0] x1, x2, z2, x3, z3, t, a, aa, b, bb, e, c, d, da, cb, nx2, nz2, nx3, nz3;
    x1 = (u >= P) ? u - P : u;
    x2 = m[255:0];  z2 = m[511:256];
    x3 = m1[255:0]; z3 = m1[511:256];
    if (kb) begin
      t = x2; x2 = x3; x3 = t;
      t = z2; z2 = z3; z3 = t;
    end
    a   = fadd(x2, z2); aa = fmul(a, a);
    b   = fsub(x2, z2); bb = fmul(b, b);
    e   = fsub(aa, bb);
    c   = fadd(x3, z3); d  = fsub(x3, z3);
    da  = fmul(d, a);   cb = fmul(c, b);
    t   = fadd(da, cb); nx3 = fmul(t, t);
    t   = fsub(da, cb); nz3 = fmul(x1, fmul(t, t));
    nx2 = fmul(aa, bb);
    nz2 = fmul(e, fadd(aa, fmul(256'd121665, e)));
    if (kb) begin
      t = nx2; nx2 = nx3; nx3 = t;
      t = nz2; nz2 = nz3; nz3 = t;
    end
    rm  = {nz2, nx2};
    rm1 = {nz3, nx3};
  endtask

  // Iteration-unit model.
  initial begin : responder
    logic [511:0] cm, cm1, rm, rm1;
    logic [263:0] cw;
    logic         cb, unstable;
    int           ce, d, resp_k, resp_epoch;
    exp_t         e;
    iter_valid = 1'b0; iter_xzm_res = '0; iter_xzm1_res = '0;
    resp_k = 0; resp_epoch = -1;
    forever begin
      @(negedge clk);
      iter_valid = 1'b0;
      if (stray_req != stray_done) begin
        stray_done++;
        iter_valid    = 1'b1;
        iter_xzm_res  = {rand256(), rand256()};
        iter_xzm1_res = {rand256(), rand256()};
      end else if (iter_en && !rst) begin
        resp_busy = 1'b1;
        cm = iter_xzm; cm1 = iter_xzm1; cw = iter_work_low; cb = iter_b; ce = epoch;
        if (ce != resp_epoch) begin
          resp_epoch = ce;
          resp_k = 0;
        end
        if (inject_issue) begin
          iter_valid    = 1'b1;
          iter_xzm_res  = {rand256(), rand256()};
          iter_xzm1_res = {rand256(), rand256()};
        end
        d = rand_delay ? int'($urandom_range(4, 1)) : 3;
        unstable = 1'b0;
        repeat (d) begin
          @(negedge clk);
          iter_valid = 1'b0;
          if (iter_xzm !== cm || iter_xzm1 !== cm1 || iter_work_low !== cw || iter_b !== cb)
            unstable = 1'b1;
        end
        case (mode)
          0:       begin rm = cm; rm1 = cm1; end
          1:       begin rm = {rand256(), rand256()}; rm1 = {rand256(), rand256()}; end
          default: ladder_step(cb, cw[255:0], cm, cm1, rm, rm1);
        endcase
        iter_valid    = 1'b1;
        iter_xzm_res  = rm;
        iter_xzm1_res = rm1;
        resp_k++;
        if (ce == epoch) begin
          check("operand_hold", 512'(unstable), 512'd0);
          e.first = 1'b0; e.cyc = cyc + 1; e.m = rm; e.m1 = rm1; e.w = exp_work;
          if (resp_k < 255) begin
            e.is_done = 1'b0;
            e.b = exp_clamped[254 - resp_k];
          end else begin
            e.is_done = 1'b1;
            e.b = 1'b0;
          end
          sb_q.push_back(e);
        end
        resp_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (iter_en) begin
        en_total++;
        if (sb_q.size() == 0) note_fail("unexpected_iter_en");
        else begin
          e = sb_q.pop_front();
          if (e.first) en_cnt = 0;
          en_cnt++;
          check("event_kind_iter", 512'(e.is_done), 512'd0);
          check("iter_en_cycle", 512'(cyc), 512'(e.cyc));
          check("iter_b", 512'(iter_b), 512'(e.b));
          check("iter_xzm", iter_xzm, e.m);
          check("iter_xzm1", iter_xzm1, e.m1);
          check("iter_work_low", 512'(iter_work_low), 512'(e.w));
          check("busy_at_iter_en", 512'(busy), 512'd1);
        end
      end
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) note_fail("unexpected_done");
        else begin
          e = sb_q.pop_front();
          check("event_kind_done", 512'(e.is_done), 512'd1);
          check("done_cycle", 512'(cyc), 512'(e.cyc));
          check("xz_out_at_done", xz_out, e.m);
          check("busy_at_done", 512'(busy), 512'd0);
          check("iterations_per_run", 512'(en_cnt), 512'd255);
        end
      end
    end
  end

  task automatic do_start(input logic [255:0] s, input logic [255:0] u);
    exp_t e;
    @(negedge clk);
    run_base    = en_total;
    exp_clamped = clamp_ref(s);
    exp_work    = {8'h0, u};
    epoch++;
    e.first = 1'b1; e.is_done = 1'b0; e.cyc = cyc + 1; e.b = exp_clamped[254];
    e.m = {256'h0, 256'h1}; e.m1 = {256'h1, u}; e.w = {8'h0, u};
    sb_q.push_back(e);
    start = 1'b1; scalar = s; u_in = u;
    @(negedge clk);
    start = 1'b0; scalar = rand256(); u_in = rand256();
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", 512'(done_cnt != d0), 512'd1);
  endtask

  task automatic wait_en(input int n, input int budget);
    int k;
    k = 0;
    while ((en_total - run_base) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("iter_en_within_budget", 512'((en_total - run_base) >= n), 512'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},     512'(busy), 512'd0);
    check({tag, "_done"},     512'(done), 512'd0);
    check({tag, "_iter_en"},  512'(iter_en), 512'd0);
    check({tag, "_iter_b"},   512'(iter_b), 512'd0);
    check({tag, "_xz_out"},   xz_out, 512'd0);
    check({tag, "_xzm"},      iter_xzm, 512'd0);
    check({tag, "_xzm1"},     iter_xzm1, 512'd0);
    check({tag, "_work_low"}, 512'(iter_work_low), 512'd0);
    check({tag, "_pos"},      512'(dut.pos), 512'd0);
    check({tag, "_state"},    512'(dut.state == IDLE), 512'd1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got time limit expected completion (%0d checks so far)", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [255:0] x, z, ures;
    int base;
    rst = 1'b1; start = 1'b0; scalar = '0; u_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    base = en_total;
    repeat (10) @(negedge clk);
    check("idle_no_iter_en", 512'(en_total), 512'(base));

    // Loopback run: scalar 0 clamps to a single set bit (254).
    mode = 0; rand_delay = 0;
    do_start(256'h0, 256'd9);
    wait_done(2500);
    check("loopback_xz_out", xz_out, {256'h0, 256'h1});

    // Stray iter_valid while idle.
    base = en_total;
    stray_req++;
    repeat (4) @(negedge clk);
    check("stray_valid_state", 512'(dut.state == IDLE), 512'd1);
    check("stray_valid_no_iter_en", 512'(en_total), 512'(base));

    // Random results, iter_valid injected during ISSUE, start pulsed during WAIT.
    mode = 1; rand_delay = 0; inject_issue = 1;
    do_start(rand256(), rand256());
    wait_en(5, 100);
    @(negedge clk);
    start = 1'b1; scalar = rand256(); u_in = rand256();
    @(negedge clk);
    start = 1'b0;
    check("start_in_wait_ignored", 512'(dut.state == WAIT), 512'd1);
    wait_done(2500);
    inject_issue = 0;

    // Mid-run reset in WAIT at iteration 100, then a full run.
    mode = 0; rand_delay = 0;
    do_start(rand256(), rand256());
    wait_en(100, 1000);
    @(negedge clk);
    rst = 1'b1;
    epoch++;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("mid_run_reset");
    base = en_total;
    repeat (10) @(negedge clk);
    check("quiesce_no_iter_en", 512'(en_total), 512'(base));
    check("quiesce_state", 512'(dut.state == IDLE), 512'd1);
    mode = 1; rand_delay = 1;
    do_start(rand256(), rand256());
    wait_done(2500);

    // Random runs.
    for (int r = 0; r < 2; r++) begin
      do_start(rand256(), rand256());
      wait_done(2500);
    end

    // RFC 7748 section 5.2 vector 1 with a real ladder step.
    mode = 2; rand_delay = 1;
    do_start(bswap(256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4),
             bswap(256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c));
    wait_done(2500);
    x = xz_out[255:0];
    z = xz_out[511:256];
    ures = fmul(x, finv(z));
    check("rfc7748_vector1", 512'(ures),
          512'(bswap(256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552)));

    repeat (8) @(negedge clk);
    check("scoreboard_drained", 512'(sb_q.size()), 512'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
